// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive front end.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  localparam logic [1:0] CfgBits5 = 2'b00;
  localparam logic [1:0] CfgBits6 = 2'b01;
  localparam logic [1:0] CfgBits7 = 2'b10;
  localparam logic [1:0] CfgBits8 = 2'b11;

  function automatic logic [3:0] bits_from_cfg(input logic [1:0] cfg);
    case (cfg)
      CfgBits5: return 4'd5;
      CfgBits6: return 4'd6;
      CfgBits7: return 4'd7;
      default:  return 4'd8;
    endcase
  endfunction

  // Unused data bits must be zero so they do not disturb the reduction.
  function automatic logic parity_error(input logic [7:0] data, input logic par_bit,
                                        input logic odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus falling-edge detect.
module uart_rx_sync (
  input  logic pclk,
  input  logic preset,
  input  logic uart_rx,
  output logic rx_sync,
  output logic rx_fall
);

  logic s1_q, s2_q, prev_q;

  // Idle-high reset values keep a reset release from looking like a start edge.
  always_ff @(posedge pclk) begin
    if (preset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= uart_rx;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign rx_sync = s2_q;
  assign rx_fall = ~s2_q & prev_q;

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: start detect, majority-voted bit sampling, one-entry holding register.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       rx_en,
  input  logic [1:0] cfg_bits,
  input  logic       cfg_par_en,
  input  logic       cfg_par_odd,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_par_err,
  output logic       rx_overrun,
  output logic       rx_break,
  output logic       rx_busy
);

  localparam logic [CNT_W-1:0] CntMax    = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] SampleLo  = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] SampleMid = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] SampleHi  = CNT_W'(BAUD_DIV / 2 + 1);

  logic rx_sync, rx_fall;

  uart_rx_sync u_sync (
    .pclk    (pclk),
    .preset  (preset),
    .uart_rx (uart_rx),
    .rx_sync (rx_sync),
    .rx_fall (rx_fall)
  );

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       votes_q, votes_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic             par_bit_q, par_bit_d;
  logic             par_err_q, par_err_d;
  logic [1:0]       cfg_bits_q, cfg_bits_d;
  logic             cfg_par_en_q, cfg_par_en_d;
  logic             cfg_par_odd_q, cfg_par_odd_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;
  logic             overrun_q, overrun_d;
  logic             break_q, break_d;

  logic       bit_done;
  logic [1:0] vote_sum;
  logic       bit_val;
  logic [3:0] nbits;

  assign nbits    = bits_from_cfg(cfg_bits_q);
  assign bit_done = (cnt_q == SampleHi);
  assign vote_sum = votes_q + {1'b0, rx_sync};
  assign bit_val  = vote_sum[1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    votes_d       = votes_q;
    shift_d       = shift_q;
    bit_idx_d     = bit_idx_q;
    par_bit_d     = par_bit_q;
    par_err_d     = par_err_q;
    cfg_bits_d    = cfg_bits_q;
    cfg_par_en_d  = cfg_par_en_q;
    cfg_par_odd_d = cfg_par_odd_q;
    data_d        = data_q;
    valid_d       = valid_q;
    ferr_d        = ferr_q;
    perr_d        = perr_q;
    overrun_d     = 1'b0;
    break_d       = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;

    if (state_q != StIdle && state_q != StBreak) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == SampleLo) begin
        votes_d = {1'b0, rx_sync};
      end else if (cnt_q == SampleMid) begin
        votes_d = vote_sum;
      end
    end

    if (state_q != StIdle && !rx_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_en && rx_fall) begin
            state_d       = StStart;
            cnt_d         = '0;
            shift_d       = '0;
            bit_idx_d     = '0;
            par_bit_d     = 1'b0;
            par_err_d     = 1'b0;
            cfg_bits_d    = cfg_bits;
            cfg_par_en_d  = cfg_par_en;
            cfg_par_odd_d = cfg_par_odd;
          end
        end
        StStart: begin
          if (bit_done) state_d = bit_val ? StIdle : StData;
        end
        StData: begin
          if (bit_done) begin
            shift_d = {bit_val, shift_q[7:1]};
            if (bit_idx_q == nbits - 4'd1) begin
              state_d = cfg_par_en_q ? StParity : StStop;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end
        end
        StParity: begin
          if (bit_done) begin
            par_bit_d = bit_val;
            par_err_d = parity_error(shift_q, bit_val, cfg_par_odd_q);
            state_d   = StStop;
          end
        end
        StStop: begin
          if (bit_done) begin
            state_d = StIdle;
            // Every sampled bit low: treat as a line break rather than a byte.
            if (!bit_val && shift_q == 8'h00 && !par_bit_q) begin
              break_d = 1'b1;
              state_d = StBreak;
            end else if (!valid_q || rx_ready) begin
              data_d  = shift_q >> (4'd8 - nbits);
              valid_d = 1'b1;
              ferr_d  = ~bit_val;
              perr_d  = par_err_q;
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
        StBreak: begin
          if (rx_sync) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      votes_q       <= '0;
      shift_q       <= '0;
      bit_idx_q     <= '0;
      par_bit_q     <= 1'b0;
      par_err_q     <= 1'b0;
      cfg_bits_q    <= '0;
      cfg_par_en_q  <= 1'b0;
      cfg_par_odd_q <= 1'b0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      ferr_q        <= 1'b0;
      perr_q        <= 1'b0;
      overrun_q     <= 1'b0;
      break_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      votes_q       <= votes_d;
      shift_q       <= shift_d;
      bit_idx_q     <= bit_idx_d;
      par_bit_q     <= par_bit_d;
      par_err_q     <= par_err_d;
      cfg_bits_q    <= cfg_bits_d;
      cfg_par_en_q  <= cfg_par_en_d;
      cfg_par_odd_q <= cfg_par_odd_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      ferr_q        <= ferr_d;
      perr_q        <= perr_d;
      overrun_q     <= overrun_d;
      break_q       <= break_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_par_err   = perr_q;
  assign rx_overrun   = overrun_q;
  assign rx_break     = break_q;
  assign rx_busy      = (state_q != StIdle);

endmodule
